btn_event_queue: RTL and testbench

//  Consumes the single-cycle press pulses from the per-button debouncers and classifies each button's

---
 rtl/btn_pkg.sv | 11 +
 rtl/btn_evt_fifo.sv | 56 +++++
 rtl/btn_event_queue.sv | 145 ++++++++++++++
 tb/tb_btn_event_queue.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types for the button click classifier and its event queue.
// Event encoding is {button index, type}; the index width follows from N_BTN.
package btn_pkg;

    typedef enum logic {EVT_SINGLE = 1'b0, EVT_DOUBLE = 1'b1} evt_type_e;

    function automatic int btn_idx_w(input int n_btn);
        return (n_btn > 1) ? $clog2(n_btn) : 1;
    endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// First-word-fall-through sync FIFO: head visible on pop_dat_o whenever empty_o=0.
// Push ignored when full at start of cycle; a same-cycle pop does not make room.
module btn_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_dat_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_dat_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push   = push_i & ~full_o;
    assign do_pop    = pop_i & ~empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/btn_event_queue.sv
// Classifies debounced press pulses per button as SINGLE/DOUBLE clicks and queues them (valid/ready).
// Event reaches evt_valid 2 cycles after its emit condition; lost events set the sticky drop_flag.
module btn_event_queue
    import btn_pkg::*;
#(
    parameter int N_BTN  = 4,
    parameter int WINDOW = 25_000_000,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_BTN-1:0]            btn_pulse,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [btn_idx_w(N_BTN):0]   evt_data,
    output logic [$clog2(DEPTH):0]      evt_count,
    output logic                        drop_flag,
    input  logic                        drop_clr
);
    localparam int IDXW = btn_idx_w(N_BTN);
    localparam int CW   = $clog2(WINDOW);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WINDOW - 1);
    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_WAIT  = 1'b1;

    typedef struct packed {
        logic [IDXW-1:0] btn_idx;
        evt_type_e       evt_type;
    } btn_evt_t;

    logic [N_BTN-1:0] emit, emit_dbl;
    logic [N_BTN-1:0] pend_v_q, pend_v_d, pend_t_q, pend_t_d;
    logic [N_BTN-1:0] gnt;
    logic             gnt_any, fifo_push, fifo_full, fifo_empty;
    logic             drop_set, drop_q, drop_d;
    btn_evt_t         push_evt;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [0:0]    st_q, st_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          emit_l, dbl_l;

        // Any pulse while waiting is a second click, even on the expiry cycle.
        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            emit_l = 1'b0;
            dbl_l  = 1'b0;
            if (st_q == ST_IDLE) begin
                if (btn_pulse[i]) begin
                    st_d  = ST_WAIT;
                    cnt_d = CNT_LOAD;
                end
            end else if (btn_pulse[i]) begin
                emit_l = 1'b1;
                dbl_l  = 1'b1;
                st_d   = ST_IDLE;
            end else if (cnt_q == '0) begin
                emit_l = 1'b1;
                st_d   = ST_IDLE;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st_q  <= ST_IDLE;
                cnt_q <= '0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
            end
        end

        assign emit[i]     = emit_l;
        assign emit_dbl[i] = dbl_l;
    end

    always_comb begin
        gnt      = '0;
        gnt_any  = 1'b0;
        push_evt = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (!gnt_any && pend_v_q[i]) begin
                gnt_any           = 1'b1;
                gnt[i]            = 1'b1;
                push_evt.btn_idx  = IDXW'(i);
                push_evt.evt_type = pend_t_q[i] ? EVT_DOUBLE : EVT_SINGLE;
            end
        end
        if (fifo_full) gnt = '0;
    end

    assign fifo_push = gnt_any & ~fifo_full;

    // A slot drained this cycle is already free for a fresh emit.
    always_comb begin
        pend_v_d = pend_v_q & ~gnt;
        pend_t_d = pend_t_q;
        drop_set = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (emit[i]) begin
                if (pend_v_d[i]) begin
                    drop_set = 1'b1;
                end else begin
                    pend_v_d[i] = 1'b1;
                    pend_t_d[i] = emit_dbl[i];
                end
            end
        end
        drop_d = drop_set ? 1'b1 : (drop_clr ? 1'b0 : drop_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_v_q <= '0;
            pend_t_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            pend_v_q <= pend_v_d;
            pend_t_q <= pend_t_d;
            drop_q   <= drop_d;
        end
    end

    btn_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IDXW + 1)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (fifo_push),
        .push_dat_i (push_evt),
        .pop_i      (evt_ready),
        .pop_dat_o  (evt_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (evt_count)
    );

    assign evt_valid = ~fifo_empty;
    assign drop_flag = drop_q;

endmodule

// File: tb/tb_btn_event_queue.sv
// Randomised and directed stimulus against a time-based reference model with an event scoreboard.
module tb_btn_event_queue;
    localparam int NB  = 4;
    localparam int WIN = 10;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] btn_pulse = '0;
    logic          evt_ready = 1'b0;
    logic          drop_clr = 1'b0;
    logic          evt_valid;
    logic [2:0]    evt_data;
    logic [2:0]    evt_count;
    logic          drop_flag;

    int n_pass = 0;
    int n_chk  = 0;

    btn_event_queue #(.N_BTN(NB), .WINDOW(WIN), .DEPTH(DEP)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_pulse (btn_pulse),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .evt_count (evt_count),
        .drop_flag (drop_flag),
        .drop_clr  (drop_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a click sequence lasts WIN cycles from the first pulse; events queue in order.
    logic [2:0] mq[$];
    logic [2:0] exp_q[$];
    bit         waiting[NB];
    int         deadline[NB];
    bit         pv[NB];
    bit         pt[NB];
    bit         mdrop = 1'b0;
    int         cyc = 0;
    int         g;
    bit         em, ty, any_drop;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            exp_q.delete();
            for (int i = 0; i < NB; i++) begin
                waiting[i] = 0; pv[i] = 0; pt[i] = 0; deadline[i] = 0;
            end
            mdrop = 0;
        end else begin
            g = -1;
            if (mq.size() < DEP)
                for (int i = NB - 1; i >= 0; i--) if (pv[i]) g = i;
            if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
            if (g >= 0) begin
                mq.push_back({g[1:0], pt[g]});
                exp_q.push_back({g[1:0], pt[g]});
                pv[g] = 0;
            end
            any_drop = 0;
            for (int i = 0; i < NB; i++) begin
                em = 0; ty = 0;
                if (waiting[i]) begin
                    if (btn_pulse[i]) begin em = 1; ty = 1; waiting[i] = 0; end
                    else if (cyc == deadline[i]) begin em = 1; waiting[i] = 0; end
                end else if (btn_pulse[i]) begin
                    waiting[i] = 1;
                    deadline[i] = cyc + WIN;
                end
                if (em) begin
                    if (pv[i]) any_drop = 1;
                    else begin pv[i] = 1; pt[i] = ty; end
                end
            end
            if (any_drop) mdrop = 1;
            else if (drop_clr) mdrop = 0;
            cyc++;
        end
    end

    // Monitor: compares the DUT against the model every cycle and pops on each accepted event.
    always @(negedge clk) begin
        chk("valid", int'(evt_valid), int'(mq.size() != 0));
        chk("count", int'(evt_count), mq.size());
        chk("drop_flag", int'(drop_flag), int'(mdrop));
        if (evt_valid) begin
            if (exp_q.size() == 0) chk("unexpected_evt", exp_q.size(), 1);
            else begin
                chk("evt_data", int'(evt_data), int'(exp_q[0]));
                if (evt_ready) void'(exp_q.pop_front());
            end
        end
    end

    int n;

    initial begin
        #1;
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_count", int'(evt_count), 0);
        chk("rst_drop", int'(drop_flag), 0);
        chk("rst_data", int'(evt_data), 0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Lone click: SINGLE on btn2 after WINDOW+2 cycles.
        btn_pulse = 4'b0100;
        tick(); btn_pulse = '0; n = 1;
        while (!evt_valid && n < 40) begin tick(); n++; end
        chk("s1_latency", n, WIN + 2);
        chk("s1_data", int'(evt_data), 3'b100);
        chk("s1_count_full", int'(evt_count), 1);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        chk("s1_count_empty", int'(evt_count), 0);
        repeat (3) tick();

        // Double click on btn1, second pulse 5 cycles after the first.
        btn_pulse = 4'b0010;
        tick(); btn_pulse = '0;
        repeat (4) tick();
        btn_pulse = 4'b0010;
        tick(); btn_pulse = '0; n = 6;
        while (!evt_valid && n < 40) begin tick(); n++; end
        chk("s2_latency", n, 7);
        chk("s2_data", int'(evt_data), 3'b011);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        repeat (20) tick();
        chk("s2_no_single", int'(evt_count), 0);

        // Simultaneous doubles on btn0 and btn3 queue in index order.
        btn_pulse = 4'b1001;
        tick(); btn_pulse = '0;
        repeat (2) tick();
        btn_pulse = 4'b1001;
        tick(); btn_pulse = '0; n = 0;
        while (evt_count != 3'd2 && n < 30) begin tick(); n++; end
        chk("s3_head0", int'(evt_data), 3'b001);
        evt_ready = 1'b1; tick();
        chk("s3_head3", int'(evt_data), 3'b111);
        tick(); evt_ready = 1'b0;
        repeat (3) tick();

        // Backpressure: 10 singles fill FIFO and all pending slots, the last two are lost.
        for (int i = 0; i < 10; i++) begin
            btn_pulse = NB'(1 << (i % NB));
            tick(); btn_pulse = '0;
            repeat (11) tick();
        end
        repeat (15) tick();
        chk("s4_count_sat", int'(evt_count), DEP);
        chk("s4_drop_set", int'(drop_flag), 1);
        drop_clr = 1'b1; tick(); drop_clr = 1'b0;
        chk("s4_drop_clr", int'(drop_flag), 0);

        // Full FIFO: pop frees a slot but the pending push waits one cycle.
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        chk("s5_count_pop", int'(evt_count), DEP - 1);
        tick();
        chk("s5_count_refill", int'(evt_count), DEP);
        evt_ready = 1'b1;
        repeat (14) tick();
        evt_ready = 1'b0;
        chk("s4_drained", int'(evt_count), 0);

        // Reset with two queued events and a click sequence in flight.
        btn_pulse = 4'b0011;
        tick(); btn_pulse = '0;
        repeat (14) tick();
        chk("s6_queued", int'(evt_count), 2);
        btn_pulse = 4'b0100;
        tick(); btn_pulse = '0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("s6_valid", int'(evt_valid), 0);
        chk("s6_count", int'(evt_count), 0);
        chk("s6_drop", int'(drop_flag), 0);
        tick(); reset = 1'b0;
        repeat (30) tick();
        chk("s6_quiet", int'(evt_valid), 0);

        // Random traffic with varying backpressure and occasional clears/reset.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NB; b++) btn_pulse[b] = ($urandom_range(0, 13) == 0);
            evt_ready = ($urandom_range(0, 3) != 0) || (c > 1200 && c < 1400 ? 1'b0 : 1'b0);
            if (c >= 1200 && c < 1400) evt_ready = ($urandom_range(0, 9) == 0);
            drop_clr  = ($urandom_range(0, 19) == 0);
            reset     = (c == 2000);
            tick();
        end
        reset = 1'b0;
        btn_pulse = '0;
        drop_clr = 1'b0;
        evt_ready = 1'b1;
        repeat (40) tick();
        chk("final_empty", int'(evt_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
